ifu: RTL and testbench



---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fifo.sv | 50 +++++
 rtl/ifu.sv | 115 +++++++++++
 tb/tb_ifu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared hxd32 fetch definitions: PC-control encodings and the prefetch entry layout.
package ifu_pkg;

    localparam int HXD_XLEN = 32;

    localparam logic PC_WR_INC  = 1'b0;
    localparam logic PC_WR_ALU  = 1'b1;
    localparam logic PC_INC_4   = 1'b0;
    localparam logic PC_INC_IMM = 1'b1;

    typedef struct packed {
        logic [HXD_XLEN-1:0] pc;
        logic [HXD_XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// In-order prefetch FIFO with registered storage, synchronous flush and occupancy count.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o = wptr - rptr;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem[rptr[AW-1:0]];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ifu.sv
// hxd32 instruction fetch unit: owns the fetch PC, issues credit-limited iram reads,
// buffers responses in order and applies decode's branch/jump redirects.
module ifu
    import ifu_pkg::*;
#(
    parameter int               XLEN     = HXD_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pc_wr_en_i,
    input  logic             pc_wr_sel_i,
    input  logic             pc_inc_sel_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic [XLEN-1:0]  imm_rd_data_i,
    output logic             iram_rd_req_o,
    output logic [XLEN-1:0]  iram_rd_addr_o,
    input  logic             iram_rd_gnt_i,
    input  logic             iram_rd_rvalid_i,
    input  logic [XLEN-1:0]  iram_rd_data_i,
    output logic             inst_valid_o,
    output logic [XLEN-1:0]  inst_data_o,
    output logic [XLEN-1:0]  inst_pc_o,
    output logic [XLEN-1:0]  pc_next_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   rpc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_rdata;
    fetch_entry_t      head;
    logic [CW:0]       credit_used;
    logic              fire;
    logic              redirect;
    logic              issue;
    logic              rvalid_live;
    logic              push;
    logic [XLEN-1:0]   target_raw;
    logic [XLEN-1:0]   target;

    assign head         = fifo_rdata;
    assign inst_valid_o = ~fifo_empty;
    assign inst_data_o  = head.data;
    assign inst_pc_o    = head.pc;
    assign pc_next_o    = head.pc + XLEN'(4);

    assign fire     = inst_valid_o & pc_wr_en_i;
    assign redirect = fire & ((pc_wr_sel_i == PC_WR_ALU) | (pc_inc_sel_i == PC_INC_IMM));

    assign target_raw = (pc_wr_sel_i == PC_WR_ALU) ? alu_data_i : head.pc + imm_rd_data_i;
    assign target     = {target_raw[XLEN-1:2], 2'b00};

    // Buffered plus in-flight words may never exceed the FIFO depth, so every
    // response always has a slot waiting for it.
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign iram_rd_req_o  = rst_n_i & (credit_used < CREDIT_MAX) & ~redirect;
    assign iram_rd_addr_o = fpc;
    assign issue          = iram_rd_req_o & iram_rd_gnt_i;

    assign rvalid_live     = iram_rd_rvalid_i & (outstanding != '0);
    assign push            = rvalid_live & (drop_cnt == '0) & ~redirect;
    assign outstanding_nxt = outstanding + CW'(issue) - CW'(rvalid_live);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fpc      <= target;
                rpc      <= target;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (issue) fpc <= fpc + XLEN'(4);
                if (push)  rpc <= rpc + XLEN'(4);
                if (rvalid_live && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (fire & ~redirect),
        .flush_i (redirect),
        .wdata_i ({rpc, iram_rd_data_i}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (!(iram_rd_rvalid_i && outstanding == '0));
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: iram model with variable grant/latency, decode model
// driving redirects, and a queue of expected PCs checked on every consumed instruction.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        pc_wr_en_i, pc_wr_sel_i, pc_inc_sel_i;
    logic [31:0] alu_data_i, imm_rd_data_i;
    logic        iram_rd_req_o;
    logic [31:0] iram_rd_addr_o;
    logic        iram_rd_gnt_i, iram_rd_rvalid_i;
    logic [31:0] iram_rd_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_data_o, inst_pc_o, pc_next_o;

    ifu dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .pc_wr_en_i       (pc_wr_en_i),
        .pc_wr_sel_i      (pc_wr_sel_i),
        .pc_inc_sel_i     (pc_inc_sel_i),
        .alu_data_i       (alu_data_i),
        .imm_rd_data_i    (imm_rd_data_i),
        .iram_rd_req_o    (iram_rd_req_o),
        .iram_rd_addr_o   (iram_rd_addr_o),
        .iram_rd_gnt_i    (iram_rd_gnt_i),
        .iram_rd_rvalid_i (iram_rd_rvalid_i),
        .iram_rd_data_i   (iram_rd_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_data_o      (inst_data_o),
        .inst_pc_o        (inst_pc_o),
        .pc_next_o        (pc_next_o)
    );

    always #5 clk = ~clk;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, fires = 0, hs_cnt = 0, rv_cnt = 0;
    int          gnt_pct = 100, lat_min = 0, lat_max = 0, br_pct = 0, stall_pct = 0;
    bit          stall = 0;
    bit          br_armed = 0, br_fired = 0, br_sel = 0, br_inc = 0;
    logic [31:0] br_pc, br_alu, br_imm;
    int          last_fire_cyc = 0, redir_cyc = 0, redir_inflight = 0;
    logic [31:0] last_fire_pc, last_hs_addr, hs_after_redir;
    bit          hs_pend = 0, prev_pend = 0;
    logic [31:0] prev_addr;

    task automatic step();
        logic [31:0] e, nxt;
        bit f, r;
        int rdy;
        @(negedge clk);
        cyc++;
        iram_rd_gnt_i = ($urandom_range(99) < gnt_pct);
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            iram_rd_rvalid_i = 1'b1;
            iram_rd_data_i   = mem_q[0].addr ^ KEY;
        end else begin
            iram_rd_rvalid_i = 1'b0;
            iram_rd_data_i   = $urandom;
        end
        pc_wr_en_i = 0; pc_wr_sel_i = 0; pc_inc_sel_i = 0;
        alu_data_i = $urandom; imm_rd_data_i = $urandom;
        if (inst_valid_o) begin
            if (br_armed && inst_pc_o == br_pc) begin
                pc_wr_en_i = 1; pc_wr_sel_i = br_sel; pc_inc_sel_i = br_inc;
                alu_data_i = br_alu; imm_rd_data_i = br_imm;
                br_armed = 0; br_fired = 1;
            end else if (!stall && $urandom_range(99) >= stall_pct) begin
                pc_wr_en_i = 1;
                if ($urandom_range(99) < br_pct) begin
                    if ($urandom_range(1) == 1) pc_wr_sel_i = 1; else pc_inc_sel_i = 1;
                    alu_data_i    = $urandom_range(0, 4095);
                    imm_rd_data_i = $urandom_range(0, 511) - 256;
                end
            end
        end else begin
            // Decode enables and selects with an empty FIFO must have no effect.
            pc_wr_en_i   = !stall;
            pc_wr_sel_i  = $urandom_range(1);
            pc_inc_sel_i = $urandom_range(1);
        end
        #4;
        f = inst_valid_o && pc_wr_en_i;
        r = f && (pc_wr_sel_i || pc_inc_sel_i);
        if (prev_pend && !r) begin
            checks++;
            if (iram_rd_req_o !== 1'b1 || iram_rd_addr_o !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: req=%b addr=%h, expected req=1 addr=%h", iram_rd_req_o, iram_rd_addr_o, prev_addr);
            end
        end
        if (r) begin
            checks++;
            if (iram_rd_req_o !== 1'b0) begin
                errors++;
                $display("FAIL req_in_redirect: req=%b, expected 0", iram_rd_req_o);
            end
        end
        if (f) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got pc %h, expected no instruction", inst_pc_o);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc_o !== e || inst_data_o !== (e ^ KEY) || pc_next_o !== e + 32'd4) begin
                    errors++;
                    $display("FAIL inst: pc=%h data=%h next=%h, expected pc=%h data=%h next=%h",
                             inst_pc_o, inst_data_o, pc_next_o, e, e ^ KEY, e + 32'd4);
                end
                if (pc_wr_sel_i)       nxt = alu_data_i;
                else if (pc_inc_sel_i) nxt = e + imm_rd_data_i;
                else                   nxt = e + 32'd4;
                nxt[1:0] = 2'b00;
                exp_q.push_back(nxt);
            end
            fires++;
            last_fire_cyc = cyc;
            last_fire_pc  = inst_pc_o;
        end
        if (r) begin
            redir_cyc      = cyc;
            redir_inflight = mem_q.size();
            hs_pend        = 1;
        end
        if (iram_rd_req_o && iram_rd_gnt_i) begin
            checks++;
            if (iram_rd_addr_o[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL addr_align: addr=%h, expected low bits 00", iram_rd_addr_o);
            end
            rdy = cyc + 1 + $urandom_range(lat_min, lat_max);
            if (mem_q.size() > 0 && rdy <= mem_q[$].ready) rdy = mem_q[$].ready + 1;
            mem_q.push_back('{addr: iram_rd_addr_o, ready: rdy});
            if (hs_pend && !r) begin
                hs_after_redir = iram_rd_addr_o;
                hs_pend = 0;
            end
            last_hs_addr = iram_rd_addr_o;
            hs_cnt++;
        end
        prev_pend = iram_rd_req_o && !iram_rd_gnt_i;
        prev_addr = iram_rd_addr_o;
        if (iram_rd_rvalid_i) begin
            void'(mem_q.pop_front());
            rv_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_i = 0; iram_rd_gnt_i = 0; iram_rd_rvalid_i = 0; pc_wr_en_i = 0;
        repeat (2) @(negedge clk);
        mem_q.delete(); exp_q.delete(); exp_q.push_back(RESET_PC);
        prev_pend = 0; hs_pend = 0; br_armed = 0; br_fired = 0; rv_cnt = 0;
        rst_n_i = 1;
    endtask

    task automatic test_reset();
        rst_n_i = 0; iram_rd_gnt_i = 0; iram_rd_rvalid_i = 0; iram_rd_data_i = 0;
        pc_wr_en_i = 0; pc_wr_sel_i = 0; pc_inc_sel_i = 0; alu_data_i = 0; imm_rd_data_i = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || iram_rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b req=%b, expected 0 0", inst_valid_o, iram_rd_req_o);
        end
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        rst_n_i = 1;
        step();
        checks++;
        if (hs_cnt != 1 || last_hs_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: grants=%0d addr=%h, expected 1 grant at %h", hs_cnt, last_hs_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int f0;
        repeat (10) step();
        f0 = fires;
        repeat (20) step();
        checks++;
        if (fires - f0 != 20) begin
            errors++;
            $display("FAIL throughput: got %0d instructions in 20 cycles, expected 20", fires - f0);
        end
    endtask

    task automatic test_stall();
        int f0;
        stall = 1;
        repeat (10) step();
        checks++;
        if (iram_rd_req_o !== 1'b0 || inst_valid_o !== 1'b1 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL stall_full: req=%b valid=%b inflight=%0d, expected 0 1 0", iram_rd_req_o, inst_valid_o, mem_q.size());
        end
        stall = 0;
        f0 = fires;
        repeat (4) step();
        checks++;
        if (fires - f0 != 4) begin
            errors++;
            $display("FAIL stall_drain: got %0d instructions in 4 cycles, expected 4", fires - f0);
        end
        repeat (10) step();
    endtask

    task automatic test_branch();
        do_reset();
        lat_min = 1; lat_max = 1;
        br_pc = 32'h10; br_sel = 0; br_inc = 1; br_imm = 32'h40; br_alu = 0; br_armed = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (br_fired && last_fire_cyc > redir_cyc) break;
        end
        checks++;
        if (!br_fired || redir_inflight != 2 || last_fire_cyc - redir_cyc != 4 || last_fire_pc !== 32'h50) begin
            errors++;
            $display("FAIL branch: fired=%0d inflight=%0d latency=%0d pc=%h, expected 1 2 4 00000050",
                     br_fired, redir_inflight, last_fire_cyc - redir_cyc, last_fire_pc);
        end
    endtask

    task automatic test_jalr();
        lat_min = 0; lat_max = 0; br_fired = 0;
        br_pc = 32'h58; br_sel = 1; br_inc = 0; br_alu = 32'h0000_1003; br_imm = 0; br_armed = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (br_fired && last_fire_cyc > redir_cyc) break;
        end
        checks++;
        if (!br_fired || hs_after_redir !== 32'h1000 || last_fire_cyc - redir_cyc != 3 || last_fire_pc !== 32'h1000) begin
            errors++;
            $display("FAIL jalr: fired=%0d fetch=%h latency=%0d pc=%h, expected 1 00001000 3 00001000",
                     br_fired, hs_after_redir, last_fire_cyc - redir_cyc, last_fire_pc);
        end
    endtask

    task automatic test_random();
        int f0;
        f0 = fires;
        gnt_pct = 60; lat_min = 0; lat_max = 4; br_pct = 15; stall_pct = 20;
        repeat (800) step();
        gnt_pct = 100; lat_min = 0; lat_max = 0; br_pct = 0; stall_pct = 0;
        repeat (20) step();
        checks++;
        if (fires - f0 < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d instructions, expected at least 100", fires - f0);
        end
    endtask

    task automatic test_reset_midop();
        int f0;
        bit hit;
        stall = 1; lat_min = 2; lat_max = 2;
        do_reset();
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_q.size() == 2 && rv_cnt == 2) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midop_setup: inflight=%0d buffered=%0d, expected 2 2", mem_q.size(), rv_cnt);
        end
        @(negedge clk);
        rst_n_i = 0; iram_rd_gnt_i = 0; iram_rd_rvalid_i = 0; pc_wr_en_i = 0;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || iram_rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: valid=%b req=%b, expected 0 0", inst_valid_o, iram_rd_req_o);
        end
        mem_q.delete(); exp_q.delete(); exp_q.push_back(RESET_PC);
        prev_pend = 0; hs_pend = 0; rv_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n_i = 1;
        stall = 0; lat_min = 0; lat_max = 0;
        step();
        checks++;
        if (last_hs_addr !== RESET_PC) begin
            errors++;
            $display("FAIL restart_fetch: addr=%h, expected %h", last_hs_addr, RESET_PC);
        end
        f0 = fires;
        repeat (20) step();
        checks++;
        if (fires - f0 < 17) begin
            errors++;
            $display("FAIL restart_stream: got %0d instructions, expected at least 17", fires - f0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_jalr();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
